multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/alu_dec.sv | 31 +++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_pkg : shared types and encodings for the multicycle controller  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] c_op_rtype  = 7'b0110011;
   localparam logic [6:0] c_op_ialu   = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;

   localparam logic [1:0] c_regsel_alu = 2'b00;
   localparam logic [1:0] c_regsel_mem = 2'b01;
   localparam logic [1:0] c_regsel_pc4 = 2'b10;

   localparam logic [3:0] c_alu_add  = 4'b0000;
   localparam logic [3:0] c_alu_sub  = 4'b0001;
   localparam logic [3:0] c_alu_and  = 4'b0010;
   localparam logic [3:0] c_alu_or   = 4'b0011;
   localparam logic [3:0] c_alu_xor  = 4'b0100;
   localparam logic [3:0] c_alu_sll  = 4'b0101;
   localparam logic [3:0] c_alu_srl  = 4'b0110;
   localparam logic [3:0] c_alu_sra  = 4'b0111;
   localparam logic [3:0] c_alu_slt  = 4'b1000;
   localparam logic [3:0] c_alu_sltu = 4'b1001;

   // Opcode/funct3 combinations that are allowed to proceed past DECODE.
   function automatic logic decode_legal(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         c_op_rtype, c_op_ialu, c_op_jal: return 1'b1;
         c_op_load, c_op_store:           return f3 == 3'b010;
         c_op_branch:                     return (f3 == 3'b000) || (f3 == 3'b001);
         default:                         return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_dec : funct3/funct7[5] to ALUControl decode for R and I types    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module alu_dec
   import ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = c_alu_add;
      case (funct3)
         // funct7[5] only means SUB for register-register ops; ADDI ignores it.
         3'b000:  alu_ctrl = (is_rtype && funct7_5) ? c_alu_sub : c_alu_add;
         3'b001:  alu_ctrl = c_alu_sll;
         3'b010:  alu_ctrl = c_alu_slt;
         3'b011:  alu_ctrl = c_alu_sltu;
         3'b100:  alu_ctrl = c_alu_xor;
         3'b101:  alu_ctrl = funct7_5 ? c_alu_sra : c_alu_srl;
         3'b110:  alu_ctrl = c_alu_or;
         default: alu_ctrl = c_alu_and;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB control FSM with trap     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] instr,
   input  logic            mem_ready,
   input  logic            alu_zero,
   output logic            ir_we,
   output logic            pc_we,
   output logic            PCsel,
   output logic            we,
   output logic            mem_re,
   output logic            mem_we,
   output logic            rs2sel,
   output logic [1:0]      regsel,
   output logic [3:0]      ALUControl,
   output logic            illegal
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [XLEN-1:0]   ir_q, ir_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       waiting;
   logic       timeout;
   logic       br_taken;
   logic [3:0] dec_alu;
   logic       unused_ir;

   assign opcode    = ir_q[6:0];
   assign funct3    = ir_q[14:12];
   assign unused_ir = ^{ir_q[XLEN-1:31], ir_q[29:15], ir_q[11:7]};

   assign waiting  = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
   assign timeout  = waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
   assign br_taken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);

   alu_dec u_alu_dec (
      .funct3   (funct3),
      .funct7_5 (ir_q[30]),
      .is_rtype (opcode == c_op_rtype),
      .alu_ctrl (dec_alu)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         ir_q    <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      wait_d  = '0;
      case (state_q)
         FETCH: begin
            if (mem_ready) begin
               ir_d    = instr;
               state_d = DECODE;
            end else if (timeout) begin
               state_d = TRAP;
            end
         end
         DECODE: state_d = decode_legal(opcode, funct3) ? EXEC : TRAP;
         EXEC: begin
            case (opcode)
               c_op_rtype, c_op_ialu:  state_d = WB;
               c_op_load, c_op_store:  state_d = MEM;
               c_op_branch, c_op_jal:  state_d = FETCH;
               default:                state_d = TRAP;
            endcase
         end
         MEM: begin
            if (mem_ready) begin
               state_d = (opcode == c_op_load) ? WB : FETCH;
            end else if (timeout) begin
               state_d = TRAP;
            end
         end
         WB:      state_d = FETCH;
         default: state_d = TRAP;
      endcase
      // Counter only advances while stalled in place; any exit clears it.
      if (waiting && !timeout) begin
         wait_d = wait_q + 1'b1;
      end
   end

   // ALU operand/op selects are only meaningful in EXEC; elsewhere they idle at ADD/readData2.
   always_comb begin
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      PCsel      = 1'b0;
      we         = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      rs2sel     = 1'b0;
      regsel     = c_regsel_alu;
      ALUControl = c_alu_add;
      illegal    = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               mem_re = !timeout;
               if (mem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            EXEC: begin
               case (opcode)
                  c_op_rtype: ALUControl = dec_alu;
                  c_op_ialu: begin
                     rs2sel     = 1'b1;
                     ALUControl = dec_alu;
                  end
                  c_op_load, c_op_store: rs2sel = 1'b1;
                  c_op_branch: begin
                     ALUControl = c_alu_sub;
                     pc_we      = br_taken;
                     PCsel      = br_taken;
                  end
                  c_op_jal: begin
                     we     = 1'b1;
                     regsel = c_regsel_pc4;
                     pc_we  = 1'b1;
                     PCsel  = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               if (!timeout) begin
                  mem_re = (opcode == c_op_load);
                  mem_we = (opcode == c_op_store);
               end
            end
            WB: begin
               we     = 1'b1;
               regsel = (opcode == c_op_load) ? c_regsel_mem : c_regsel_alu;
            end
            TRAP:    illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_ctrl : trace-model bench for the multicycle controller |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_multicycle_ctrl;

   localparam int TO        = 15;
   localparam int TRAP_HOLD = 20;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_J  = 7'b1101111;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        mem_ready;
   logic        alu_zero;
   logic        ir_we, pc_we, PCsel, we, mem_re, mem_we, rs2sel, illegal;
   logic [1:0]  regsel;
   logic [3:0]  ALUControl;
   logic [13:0] obs;

   int ntests = 0;
   int nfail  = 0;

   typedef struct packed {
      logic        ready;
      logic        fetch;
      logic        z;
      logic [13:0] out;
   } step_t;

   step_t plan[$];

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .mem_ready  (mem_ready),
      .alu_zero   (alu_zero),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .PCsel      (PCsel),
      .we         (we),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .rs2sel     (rs2sel),
      .regsel     (regsel),
      .ALUControl (ALUControl),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   assign obs = {ir_we, pc_we, PCsel, we, mem_re, mem_we, rs2sel, regsel, ALUControl, illegal};

   function automatic logic [13:0] pk(bit irwe, bit pcwe, bit pcsel, bit wen, bit mre, bit mwe,
                                      bit r2, logic [1:0] rs, logic [3:0] alu, bit ill);
      return {irwe, pcwe, pcsel, wen, mre, mwe, r2, rs, alu, ill};
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(1, 0));
   endfunction

   // ALU operation named by the ISA for a given funct3/funct7[5].
   function automatic logic [3:0] exp_alu(logic [2:0] f3, bit f7, bit rtype);
      case (f3)
         3'd0:    return (rtype && f7) ? 4'd1 : 4'd0;
         3'd1:    return 4'd5;
         3'd2:    return 4'd8;
         3'd3:    return 4'd9;
         3'd4:    return 4'd4;
         3'd5:    return f7 ? 4'd7 : 4'd6;
         3'd6:    return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   task automatic add(input bit rdy, input bit ftch, input bit z, input logic [13:0] o);
      step_t s;
      s.ready = rdy;
      s.fetch = ftch;
      s.z     = z;
      s.out   = o;
      plan.push_back(s);
   endtask

   task automatic add_trap(input int n);
      for (int i = 0; i < n; i++) add(rb(), 1'b0, rb(), pk(0,0,0,0,0,0,0,2'b00,4'd0,1));
   endtask

   // Expected cycle-by-cycle behaviour of one instruction; fw/mw are stall cycles
   // on mem_ready in FETCH/MEM (>= TO means the stall runs into the timeout).
   task automatic plan_instr(input logic [31:0] ins, input int fw, input int mw, input bit z);
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [13:0] mstb;
      bit          f7, legal, taken;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[30];
      if (fw >= TO) begin
         for (int i = 0; i < TO - 1; i++) add(0, 0, rb(), pk(0,0,0,0,1,0,0,2'b00,4'd0,0));
         add(0, 0, rb(), '0);
         add_trap(5);
         return;
      end
      for (int i = 0; i < fw; i++) add(0, 0, rb(), pk(0,0,0,0,1,0,0,2'b00,4'd0,0));
      add(1, 1, rb(), pk(1,1,0,0,1,0,0,2'b00,4'd0,0));
      add(rb(), 0, rb(), '0);
      legal = (op == OP_R) || (op == OP_I) || (op == OP_J) ||
              (((op == OP_LD) || (op == OP_ST)) && (f3 == 3'b010)) ||
              ((op == OP_BR) && (f3[2:1] == 2'b00));
      if (!legal) begin
         add_trap(TRAP_HOLD);
         return;
      end
      case (op)
         OP_R: begin
            add(rb(), 0, rb(), pk(0,0,0,0,0,0,0,2'b00,exp_alu(f3, f7, 1'b1),0));
            add(rb(), 0, rb(), pk(0,0,0,1,0,0,0,2'b00,4'd0,0));
         end
         OP_I: begin
            add(rb(), 0, rb(), pk(0,0,0,0,0,0,1,2'b00,exp_alu(f3, f7, 1'b0),0));
            add(rb(), 0, rb(), pk(0,0,0,1,0,0,0,2'b00,4'd0,0));
         end
         OP_LD, OP_ST: begin
            add(rb(), 0, rb(), pk(0,0,0,0,0,0,1,2'b00,4'd0,0));
            mstb = (op == OP_LD) ? pk(0,0,0,0,1,0,0,2'b00,4'd0,0) : pk(0,0,0,0,0,1,0,2'b00,4'd0,0);
            if (mw >= TO) begin
               for (int i = 0; i < TO - 1; i++) add(0, 0, rb(), mstb);
               add(0, 0, rb(), '0);
               add_trap(5);
               return;
            end
            for (int i = 0; i < mw; i++) add(0, 0, rb(), mstb);
            add(1, 0, rb(), mstb);
            if (op == OP_LD) add(rb(), 0, rb(), pk(0,0,0,1,0,0,0,2'b01,4'd0,0));
         end
         OP_BR: begin
            taken = (f3 == 3'b000) ? z : !z;
            add(rb(), 0, z, pk(0,taken,taken,0,0,0,0,2'b00,4'd1,0));
         end
         default: add(rb(), 0, rb(), pk(0,1,1,1,0,0,0,2'b10,4'd0,0));
      endcase
   endtask

   task automatic check(input string tag, input int idx, input logic [13:0] e);
      ntests++;
      assert (obs === e) else begin
         nfail++;
         $error("FAIL %s step %0d: observed %h expected %h", tag, idx, obs, e);
      end
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic run_plan(input string tag, input logic [31:0] ins, input int limit);
      int n;
      n = (limit < 0 || limit > plan.size()) ? plan.size() : limit;
      for (int i = 0; i < n; i++) begin
         mem_ready = plan[i].ready;
         alu_zero  = plan[i].z;
         instr     = plan[i].fetch ? ins : $urandom();
         @(negedge clk);
         check(tag, i, plan[i].out);
         @(posedge clk);
         #1;
      end
      plan.delete();
   endtask

   task automatic do_reset(input string tag);
      reset     = 1'b1;
      mem_ready = rb();
      #1;
      check(tag, 0, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(5, 0))
         0: w[6:0] = OP_R;
         1: w[6:0] = OP_I;
         2: begin w[6:0] = OP_LD; w[14:12] = 3'b010; end
         3: begin w[6:0] = OP_ST; w[14:12] = 3'b010; end
         4: begin w[6:0] = OP_BR; w[14:12] = {2'b00, rb()}; end
         default: w[6:0] = OP_J;
      endcase
      return w;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      int fw, mw;
      reset     = 1'b1;
      mem_ready = 1'b0;
      instr     = 32'h0;
      alu_zero  = 1'b0;
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      instr     = 32'h003100B3;
      @(negedge clk);
      check("reset_idle", 0, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      plan_instr(32'h003100B3, 0, 0, 0);  run_plan("rtype_add", 32'h003100B3, -1);
      plan_instr(32'h0000A103, 0, 3, 0);  run_plan("lw_wait3", 32'h0000A103, -1);
      plan_instr(32'h00208463, 0, 0, 1);  run_plan("beq_taken", 32'h00208463, -1);
      plan_instr(32'h00208463, 2, 0, 0);  run_plan("beq_not_taken", 32'h00208463, -1);
      plan_instr(32'h00209463, 0, 0, 0);  run_plan("bne_taken", 32'h00209463, -1);
      plan_instr(32'h40A55513, 0, 0, 0);  run_plan("srai", 32'h40A55513, -1);
      plan_instr(32'h40000513, 0, 0, 0);  run_plan("addi_f7", 32'h40000513, -1);
      plan_instr(32'h003100B3, TO - 1, 0, 0); run_plan("fetch_wait_max", 32'h003100B3, -1);
      plan_instr(32'h0020A223, 0, TO - 1, 0); run_plan("sw_wait_max", 32'h0020A223, -1);

      plan_instr(32'h0000007F, 0, 0, 0);  run_plan("bad_opcode", 32'h0000007F, -1);
      do_reset("reset_after_trap");
      plan_instr(32'h00A02463, 1, 0, 0);  run_plan("bad_br_f3", 32'h00A02463, -1);
      do_reset("reset_after_br");
      plan_instr(32'h00008103, 0, 0, 0);  run_plan("bad_ld_f3", 32'h00008103, -1);
      do_reset("reset_after_ld");
      plan_instr(32'h003100B3, TO, 0, 0); run_plan("fetch_timeout", 32'h003100B3, -1);
      do_reset("reset_after_fto");
      plan_instr(32'h0020A223, 0, TO, 0); run_plan("store_timeout", 32'h0020A223, -1);
      do_reset("reset_after_sto");

      // Abort a store while it is stalled in MEM.
      plan_instr(32'h0020A223, 0, 5, 0);  run_plan("store_abort", 32'h0020A223, 4);
      mem_ready = 1'b0;
      #1;
      check("store_abort_mem", 0, pk(0,0,0,0,0,1,0,2'b00,4'd0,0));
      do_reset("store_abort_rst");
      plan_instr(32'h0000A103, 2, 1, 0); run_plan("after_abort", 32'h0000A103, -1);

      for (int k = 0; k < 40; k++) begin
         w  = rand_instr();
         fw = ($urandom_range(7, 0) == 0) ? TO - 1 : int'($urandom_range(2, 0));
         mw = ($urandom_range(7, 0) == 0) ? TO - 1 : int'($urandom_range(3, 0));
         plan_instr(w, fw, mw, rb());
         run_plan("random", w, -1);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
`default_nettype wire
